lut_1058_scan_ctrl: RTL and testbench
=====================================

Name: lut_1058_scan_ctrl

Overview:
- Sequencer that sweeps the 4-bit input of one lut_1058 instance through all 16 codes and records which codes assert s.
- Produces a 16-bit match mask, a match count and the lowest matching code.
- Uses a start/done/ack handshake.
- Sits between the top-level control (or test harness) and the lut_1058 decode datapath. Used for self-check of the `Aone..`Done code set at power-up.

Parameters:
DWELL, 1, cycles each code is held on b before s is sampled (legal range 1..255)

Ports:
clk          input   1   system clock, all logic rising-edge
rst_n        input   1   synchronous reset, active-low
start_i      input   1   request a scan; sampled only in IDLE or DONE
abort_i      input   1   cancel a running scan
ack_i        input   1   consumer has read the results; releases DONE
busy_o       output  1   high while scanning
done_o       output  1   results valid; level, held until ack_i or start_i
mask_o       output  16  bit k = lut_1058 s for b = k
match_cnt_o  output  5   popcount of mask_o (0..16)
first_o      output  4   lowest k with mask_o[k]=1; 0 if none
first_vld_o  output  1   at least one match found
code_o       output  4   code currently driven onto lut_1058 b (debug)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0, including mask, counts, code_o and the dwell counter.
  - Reset applied mid-scan aborts the scan the same way.
- States: IDLE, SCAN, DONE. Encoding is a shared enum.
- IDLE:
  - On start_i=1 go to SCAN.
  - Clear mask, match_cnt, first_o and first_vld_o.
  - Load code=0 and dwell=0.
  - busy_o goes high the cycle after start_i.
- SCAN:
  - code register drives lut_1058 b directly. s is combinational from the registered code.
  - Each cycle, dwell increments.
  - When dwell==DWELL-1:
    - Write mask[code]<=s.
    - If s=1, increment match_cnt.
    - If s=1 and first_vld=0, set first_o<=code and first_vld<=1.
    - Reset dwell to 0 and increment code.
  - After code 15 is sampled, go to DONE. Code wraps to 0 and is not driven further.
  - Scan length from the start_i edge to the done_o rise is exactly 16*DWELL+1 cycles.
- abort_i in SCAN:
  - Go to IDLE next cycle.
  - Clear mask, counts, first and code. done_o stays 0.
  - abort_i has priority over the final sample, so an abort on the last dwell cycle discards that result.
  - abort_i is ignored outside SCAN.
- DONE:
  - done_o=1, busy_o=0. Results are stable.
  - ack_i=1: go to IDLE. Results are retained, done_o drops next cycle.
  - start_i=1: restart the scan directly, with clear as in IDLE. start_i beats ack_i if both are high.
- start_i in SCAN is ignored (no queuing).
- match_cnt is 5 bits so that 16 matches do not overflow. It saturation-free counts 0..16.
- DWELL=1: one sample per cycle and no idle cycles between codes.
- All outputs are registered, except code_o, which is the code register itself.

Decomposition:
- Package lut_scan_pkg holds:
  - state_t enum {IDLE, SCAN, DONE}
  - CODE_W=4, NCODES=16, CNT_W=5
- One sub-module: the existing lut_1058, instantiated once as u_lut with b=code and s=lut_s.
- Dwell counter and result registers live inline in the controller. No further split.

Test Plan:
1. Reset, DWELL=1: hold rst_n=0 for 3 cycles during random start_i -> all outputs 0; state IDLE.
2. DWELL=1, pulse start_i:
   - done_o rises exactly 17 cycles later.
   - mask_o has bits set only at `Aone, `Bone, `Cone and `Done (distinct) -> match_cnt_o=4.
   - first_o = min of the four codes; first_vld_o=1.
3. DWELL=3, start_i:
   - code_o holds each value for 3 cycles, 0..15 in order.
   - done_o rises after 49 cycles; same mask as scenario 2.
4. Abort: start_i, then abort_i while code_o=7 -> IDLE next cycle; mask_o=0, match_cnt_o=0, done_o never asserts.
5. Handshake:
   - In DONE, hold ack_i=0 for 10 cycles -> done_o and results stable.
   - Then ack_i=1 -> done_o=0 next cycle with results retained.
   - Then start_i -> results cleared, and done_o reasserts 17 cycles later.
6. Corner cases:
   - start_i pulsed during SCAN -> ignored, scan length unchanged.
   - start_i and ack_i together in DONE -> restart wins.
   - rst_n=0 mid-scan -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lut_scan_pkg.sv
// Shared types and constants for the lut_1058 code-sweep controller.
// Holds the scan FSM state enum, widths and the decoded code set.
package lut_scan_pkg;

  localparam int CODE_W = 4;
  localparam int NCODES = 16;
  localparam int CNT_W  = 5;

  localparam logic [CODE_W-1:0] A_ONE = 4'd2;
  localparam logic [CODE_W-1:0] B_ONE = 4'd5;
  localparam logic [CODE_W-1:0] C_ONE = 4'd9;
  localparam logic [CODE_W-1:0] D_ONE = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lut_1058.sv
// Decode datapath: s is high for the four codes A_ONE..D_ONE.
// Ports: b (4-bit code in), s (match out, combinational).
import lut_scan_pkg::*;

module lut_1058 (
  input  logic [CODE_W-1:0] b,
  output logic              s
);

  assign s = (b == A_ONE) | (b == B_ONE)
           | (b == C_ONE) | (b == D_ONE);

endmodule

// File: rtl/lut_1058_scan_ctrl.sv
// Sweeps lut_1058 through all codes, builds match mask/count/first.
// Ports: clk, rst_n, start_i/abort_i/ack_i in; busy/done/results out.
import lut_scan_pkg::*;

module lut_1058_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NCODES-1:0] mask_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic [CODE_W-1:0] first_o,
  output logic              first_vld_o,
  output logic [CODE_W-1:0] code_o
);

  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
  localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(NCODES - 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [7:0]        dwell_q, dwell_d;
  logic [NCODES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] first_q, first_d;
  logic              fvld_q, fvld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr;
  logic              lut_s;

  lut_1058 u_lut (
    .b (code_q),
    .s (lut_s)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fvld_d  = fvld_q;
    busy_d  = busy_q;
    done_d  = done_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          clr     = 1'b1;
          state_d = SCAN;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (abort_i) begin
          clr     = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (dwell_q == DW_LAST) begin
          mask_d[code_q] = lut_s;
          if (lut_s) cnt_d = cnt_q + 5'd1;
          if (lut_s && !fvld_q) begin
            first_d = code_q;
            fvld_d  = 1'b1;
          end
          dwell_d = 8'd0;
          code_d  = code_q + 4'd1;
          if (code_q == CODE_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      DONE: begin
        // restart takes precedence over ack
        if (start_i) begin
          clr     = 1'b1;
          state_d = SCAN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else if (ack_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    if (clr) begin
      code_d  = '0;
      dwell_d = '0;
      mask_d  = '0;
      cnt_d   = '0;
      first_d = '0;
      fvld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      fvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      fvld_q  <= fvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mask_o      = mask_q;
  assign match_cnt_o = cnt_q;
  assign first_o     = first_q;
  assign first_vld_o = fvld_q;
  assign code_o      = code_q;

endmodule

// File: tb/tb_lut_1058_scan_ctrl.sv
// Bench for lut_1058_scan_ctrl: DWELL=1 and DWELL=3 instances.
// Scoreboard queues hold expected scan results and code sequence.
module tb_lut_1058_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, abort1, ack1;
  logic start3, abort3, ack3;

  logic        busy1, done1, fvld1;
  logic [15:0] mask1;
  logic [4:0]  cnt1;
  logic [3:0]  first1, code1;

  logic        busy3, done3, fvld3;
  logic [15:0] mask3;
  logic [4:0]  cnt3;
  logic [3:0]  first3, code3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        fvld;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   code_sb[$];

  localparam logic [3:0] CODES [4] =
    '{4'd2, 4'd5, 4'd9, 4'd14};

  lut_1058_scan_ctrl #(.DWELL(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start1),
    .abort_i     (abort1),
    .ack_i       (ack1),
    .busy_o      (busy1),
    .done_o      (done1),
    .mask_o      (mask1),
    .match_cnt_o (cnt1),
    .first_o     (first1),
    .first_vld_o (fvld1),
    .code_o      (code1)
  );

  lut_1058_scan_ctrl #(.DWELL(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start3),
    .abort_i     (abort3),
    .ack_i       (ack3),
    .busy_o      (busy3),
    .done_o      (done3),
    .mask_o      (mask3),
    .match_cnt_o (cnt3),
    .first_o     (first3),
    .first_vld_o (fvld3),
    .code_o      (code3)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_scan(int dwell);
    exp_t e;
    e.mask  = '0;
    e.cnt   = '0;
    e.first = '0;
    e.fvld  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bit hit = 1'b0;
      for (int j = 0; j < 4; j++)
        if (CODES[j] == 4'(k)) hit = 1'b1;
      if (hit) begin
        e.mask[k] = 1'b1;
        e.cnt = e.cnt + 5'd1;
        if (!e.fvld) begin
          e.first = 4'(k);
          e.fvld  = 1'b1;
        end
      end
    end
    e.lat = 16 * dwell + 1;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(inout int n);
    while (!done1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start1 = 1'($urandom_range(0, 1));
      start3 = 1'($urandom_range(0, 1));
      tick();
    end
    total++;
    if ({busy1, done1, mask1, cnt1, first1, fvld1, code1} !== 32'd0) begin
      bad++;
      $display("FAIL reset_d1 got=%h want=0",
        {busy1, done1, mask1, cnt1, first1, fvld1, code1});
    end
    total++;
    if ({busy3, done3, mask3, cnt3, first3, fvld3, code3} !== 32'd0) begin
      bad++;
      $display("FAIL reset_d3 got=%h want=0",
        {busy3, done3, mask3, cnt3, first3, fvld3, code3});
    end
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b1;
    tick();
    total++;
    if ({busy1, done1, busy3, done3} !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=0000",
        {busy1, done1, busy3, done3});
    end
  endtask

  task automatic test_scan1;
    exp_t e;
    int n;
    sb.push_back(exp_scan(1));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL scan1_busy got=%b want=1", busy1);
    end
    wait_done1(n);
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin
      bad++;
      $display("FAIL scan1_lat got=%0d want=%0d", n, e.lat);
    end
    total++;
    if ({mask1, cnt1, first1, fvld1} !== {e.mask, e.cnt, e.first, e.fvld}) begin
      bad++;
      $display("FAIL scan1_res got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
        mask1, cnt1, first1, fvld1, e.mask, e.cnt, e.first, e.fvld);
    end
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL scan1_busy_done got=%b want=0", busy1);
    end
  endtask

  task automatic test_dwell3;
    exp_t e;
    int n;
    int c;
    sb.push_back(exp_scan(3));
    for (int k = 0; k < 16; k++)
      for (int r = 0; r < 3; r++)
        code_sb.push_back(k);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 200) begin
      if (code_sb.size() > 0) begin
        c = code_sb.pop_front();
        total++;
        if (code3 !== 4'(c)) begin
          bad++;
          $display("FAIL dwell3_code cyc=%0d got=%0d want=%0d",
            n, code3, c);
        end
      end
      tick();
      n++;
    end
    total++;
    if (code_sb.size() !== 0) begin
      bad++;
      $display("FAIL dwell3_codes_left got=%0d want=0",
        code_sb.size());
      code_sb.delete();
    end
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin
      bad++;
      $display("FAIL dwell3_lat got=%0d want=%0d", n, e.lat);
    end
    total++;
    if ({mask3, cnt3, first3, fvld3} !== {e.mask, e.cnt, e.first, e.fvld}) begin
      bad++;
      $display("FAIL dwell3_res got=%h/%0d/%0d want=%h/%0d/%0d",
        mask3, cnt3, first3, e.mask, e.cnt, e.first);
    end
  endtask

  task automatic test_abort;
    int n;
    bit seen;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (code1 !== 4'd7 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (code1 !== 4'd7) begin
      bad++;
      $display("FAIL abort_reach7 got=%0d want=7", code1);
    end
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    total++;
    if ({busy1, done1, mask1, cnt1, fvld1, code1} !== 28'd0) begin
      bad++;
      $display("FAIL abort_clear got=%b/%b/%h/%0d/%b/%0d want=0",
        busy1, done1, mask1, cnt1, fvld1, code1);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done1 || busy1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_stay_idle got=%b want=0", seen);
    end
  endtask

  task automatic test_handshake;
    exp_t e;
    int n;
    sb.push_back(exp_scan(1));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    wait_done1(n);
    e = sb.pop_front();
    total++;
    if (n !== e.lat || mask1 !== e.mask) begin
      bad++;
      $display("FAIL hs_scan got=%0d/%h want=%0d/%h",
        n, mask1, e.lat, e.mask);
    end
    abort1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({done1, busy1, mask1, cnt1, first1} !== {2'b10, e.mask, e.cnt, e.first}) begin
        bad++;
        $display("FAIL hs_hold cyc=%0d got=%b/%h/%0d want=1/%h/%0d",
          i, done1, mask1, cnt1, e.mask, e.cnt);
      end
    end
    abort1 = 1'b0;
    ack1   = 1'b1;
    tick();
    ack1   = 1'b0;
    total++;
    if ({done1, busy1, mask1, cnt1, first1, fvld1} !==
        {2'b00, e.mask, e.cnt, e.first, e.fvld}) begin
      bad++;
      $display("FAIL hs_ack got=%b/%h/%0d/%0d want=0/%h/%0d/%0d",
        done1, mask1, cnt1, first1, e.mask, e.cnt, e.first);
    end
    sb.push_back(exp_scan(1));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    total++;
    if ({busy1, mask1, cnt1, fvld1} !== {1'b1, 22'd0}) begin
      bad++;
      $display("FAIL hs_restart_clr got=%b/%h/%0d/%b want=1/0/0/0",
        busy1, mask1, cnt1, fvld1);
    end
    wait_done1(n);
    e = sb.pop_front();
    total++;
    if (n !== e.lat || mask1 !== e.mask) begin
      bad++;
      $display("FAIL hs_rescan got=%0d/%h want=%0d/%h",
        n, mask1, e.lat, e.mask);
    end
  endtask

  task automatic test_corners;
    exp_t e;
    int n;
    sb.push_back(exp_scan(1));
    start1 = 1'b1;
    tick();
    n = 1;
    while (!done1 && n < 200) begin
      start1 = (n == 5 || n == 9);
      tick();
      n++;
    end
    start1 = 1'b0;
    e = sb.pop_front();
    total++;
    if (n !== e.lat || mask1 !== e.mask) begin
      bad++;
      $display("FAIL start_in_scan got=%0d/%h want=%0d/%h",
        n, mask1, e.lat, e.mask);
    end
    sb.push_back(exp_scan(1));
    start1 = 1'b1;
    ack1   = 1'b1;
    tick();
    start1 = 1'b0;
    ack1   = 1'b0;
    n = 1;
    total++;
    if ({busy1, done1, mask1} !== {2'b10, 16'd0}) begin
      bad++;
      $display("FAIL start_ack got=%b/%b/%h want=1/0/0",
        busy1, done1, mask1);
    end
    wait_done1(n);
    e = sb.pop_front();
    total++;
    if (n !== e.lat || cnt1 !== e.cnt) begin
      bad++;
      $display("FAIL start_ack_scan got=%0d/%0d want=%0d/%0d",
        n, cnt1, e.lat, e.cnt);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({busy1, done1, mask1, cnt1, first1, fvld1, code1} !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h want=0",
        {busy1, done1, mask1, cnt1, first1, fvld1, code1});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    ack1   = 1'b0;
    start3 = 1'b0;
    abort3 = 1'b0;
    ack3   = 1'b0;
    test_reset();
    test_scan1();
    test_dwell3();
    test_abort();
    test_handshake();
    test_corners();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
